wrr_pop_controller: RTL and testbench
=====================================

WRR_POP_CONTROLLER -- requirements
Module: wrr_pop_controller

Interface
REQ-001 SHALL have parameter QUEUE_QUANTITY, default 4, number of source FIFOs.
REQ-002 SHALL have parameter DATA_BITS, default 8, FIFO word width.
REQ-003 SHALL have parameter MAX_WEIGHT, default 64; WEIGHT_BITS = $clog2(MAX_WEIGHT).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enb  input  1  global enable; low freezes all state.
REQ-007 SHALL have port pesos  input  QUEUE_QUANTITY*WEIGHT_BITS  per-queue weight; queue i at bits [i*WEIGHT_BITS +: WEIGHT_BITS].
REQ-008 SHALL have port buf_empty  input  QUEUE_QUANTITY  per-queue FIFO empty flag.
REQ-009 SHALL have port fifo_data  input  QUEUE_QUANTITY*DATA_BITS  show-ahead head word of each FIFO.
REQ-010 SHALL have port out_ready  input  1  downstream can accept a word this cycle.
REQ-011 SHALL have port pop  output  QUEUE_QUANTITY  one-hot FIFO pop strobe, combinational.
REQ-012 SHALL have port data_out  output  DATA_BITS  registered popped word.
REQ-013 SHALL have port valid_out  output  1  data_out valid, registered.
REQ-014 SHALL have port selector  output  $clog2(QUEUE_QUANTITY)  queue currently granted.
REQ-015 SHALL have port selector_enb  output  1  high while a grant is being served.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SERVE; pointer ptr and credit counter (WEIGHT_BITS wide).
REQ-017 IDLE -> LOAD when enb and any queue has !buf_empty and nonzero weight; otherwise stay IDLE.
REQ-018 LOAD: search from ptr upward, wrapping N-1 -> 0, for first queue with !buf_empty and weight != 0; if found, selector <= q, credit <= pesos[q], -> SERVE; else -> IDLE.
REQ-019 Weight 0 SHALL mean the queue is never granted.
REQ-020 pop[selector] SHALL be 1 only when state==SERVE, enb, out_ready, !buf_empty[selector]; all other pop bits 0.
REQ-021 On a pop edge: data_out <= fifo_data[selector], valid_out <= 1, credit <= credit-1; on any non-pop edge valid_out <= 0 (latency pop->valid_out = 1 cycle).
REQ-022 SERVE -> LOAD with ptr <= selector+1 (mod QUEUE_QUANTITY) when a pop occurs with credit==1, or when buf_empty[selector] is high (remaining credit discarded).
REQ-023 out_ready low in SERVE: no pop, credit and state held, selector held.
REQ-024 enb low: pop=0, valid_out <= 0, all other registers held; resumes exactly where frozen.
REQ-025 selector_enb SHALL equal (state==SERVE).
REQ-026 Weight changes SHALL take effect only at the next LOAD.

Reset
REQ-027 On rst at a clock edge: state IDLE, ptr 0, credit 0, selector 0, selector_enb 0, valid_out 0, data_out 0; pop 0 while rst high.
REQ-028 rst SHALL override enb and abort any grant mid-SERVE without a pop on that edge.

Configuration
REQ-029 Macro WRR_GRANT_COUNT_EN, when defined, SHALL add output grant_total (16 bits): count of pops since reset, saturating at 16'hFFFF, cleared by rst, held when enb low.
REQ-030 Without WRR_GRANT_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package/header SHALL hold FSM state encoding and default parameter values (QUEUE_QUANTITY, DATA_BITS, MAX_WEIGHT).
REQ-032 Rotating-priority search SHALL be a sub-module wrr_next_queue (inputs ptr, eligible mask; outputs found, index).

Verification
REQ-033 Weights {1,1,1,1}, all non-empty, out_ready=1 -> pops cycle q0,q1,q2,q3,q0 with one LOAD cycle between grants.
REQ-034 Weights {3,1,0,2} (q0..q3), all non-empty -> per round 3 pops q0, 1 pop q1, none q2, 2 pops q3.
REQ-035 q1 granted weight 5, buf_empty[1] rises after 2 pops -> SERVE exits, next LOAD grants q2.
REQ-036 out_ready low 3 cycles mid-SERVE -> pop 0, credit held, valid_out 0; resumes with identical credit.
REQ-037 rst asserted in SERVE with credit 4 -> next cycle all outputs at reset values, selector 0, no pop on rst edge.
REQ-038 With WRR_GRANT_COUNT_EN, 10 pops -> grant_total==10; after rst -> 0.

Source files
------------

// File: rtl/wrr_pop_controller_pkg.sv
// Shared definitions for the weighted round-robin pop controller:
// default parameter values and the FSM state encoding.
package wrr_pop_controller_pkg;

    localparam int unsigned DEFAULT_QUEUE_QUANTITY = 4;
    localparam int unsigned DEFAULT_DATA_BITS      = 8;
    localparam int unsigned DEFAULT_MAX_WEIGHT     = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StServe = 2'd2
    } wrr_state_e;

endpackage

// File: rtl/wrr_pop_controller_if.sv
// FIFO-side and downstream-side signals of the WRR pop controller.
// master = controller, slave = FIFO bank plus downstream consumer.
interface wrr_pop_controller_if
    import wrr_pop_controller_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = DEFAULT_QUEUE_QUANTITY,
    parameter int unsigned DATA_BITS      = DEFAULT_DATA_BITS
);
    localparam int unsigned SEL_BITS = $clog2(QUEUE_QUANTITY);

    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic                                out_ready;
    logic [DATA_BITS-1:0]                data_out;
    logic                                valid_out;
    logic [SEL_BITS-1:0]                 selector;
    logic                                selector_enb;

    modport master (
        input  buf_empty, fifo_data, out_ready,
        output pop, data_out, valid_out, selector, selector_enb
    );

    modport slave (
        output buf_empty, fifo_data, out_ready,
        input  pop, data_out, valid_out, selector, selector_enb
    );

endinterface

// File: rtl/wrr_next_queue.sv
// Rotating-priority search: first eligible queue at or after ptr,
// wrapping from N-1 back to 0.
module wrr_next_queue
    import wrr_pop_controller_pkg::*;
#(
    parameter int unsigned N = DEFAULT_QUEUE_QUANTITY,
    localparam int unsigned SEL_BITS = $clog2(N)
) (
    input  logic [SEL_BITS-1:0] ptr,
    input  logic [N-1:0]        eligible,
    output logic                found,
    output logic [SEL_BITS-1:0] index
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && eligible[cand]) begin
                found = 1'b1;
                index = SEL_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/wrr_pop_controller.sv
// Weighted round-robin pop controller: grants one FIFO at a time for up to
// its weight in pops. Optional macro WRR_GRANT_COUNT_EN adds grant_total.
module wrr_pop_controller
    import wrr_pop_controller_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = DEFAULT_QUEUE_QUANTITY,
    parameter int unsigned DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int unsigned MAX_WEIGHT     = DEFAULT_MAX_WEIGHT,
    localparam int unsigned WEIGHT_BITS   = $clog2(MAX_WEIGHT),
    localparam int unsigned SEL_BITS      = $clog2(QUEUE_QUANTITY)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
`ifdef WRR_GRANT_COUNT_EN
    output logic [15:0]                         grant_total,
`endif
    wrr_pop_controller_if.master                bus
);

    wrr_state_e             state_q;
    logic [SEL_BITS-1:0]    ptr_q;
    logic [SEL_BITS-1:0]    selector_q;
    logic [WEIGHT_BITS-1:0] credit_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   serving_q;

    logic [DATA_BITS-1:0]      head   [QUEUE_QUANTITY];
    logic [WEIGHT_BITS-1:0]    weight [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic                      found;
    logic [SEL_BITS-1:0]       found_idx;
    logic [SEL_BITS-1:0]       next_ptr;
    logic                      pop_fire;
    logic [QUEUE_QUANTITY-1:0] pop_vec;

    always_comb begin
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            head[i]     = bus.fifo_data[i*DATA_BITS +: DATA_BITS];
            weight[i]   = pesos[i*WEIGHT_BITS +: WEIGHT_BITS];
            eligible[i] = !bus.buf_empty[i] && (weight[i] != '0);
        end
    end

    wrr_next_queue #(
        .N (QUEUE_QUANTITY)
    ) u_next_queue (
        .ptr      (ptr_q),
        .eligible (eligible),
        .found    (found),
        .index    (found_idx)
    );

    assign next_ptr = (32'(selector_q) == QUEUE_QUANTITY - 1) ? '0 : selector_q + 1'b1;

    // Reset gates the strobe so an aborted grant never pops the FIFO.
    assign pop_fire = (state_q == StServe) && enb && !rst && bus.out_ready
                      && !bus.buf_empty[selector_q];

    always_comb begin
        pop_vec = '0;
        if (pop_fire) begin
            pop_vec[selector_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            selector_q <= '0;
            credit_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            serving_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (enb) begin
                unique case (state_q)
                    StIdle: begin
                        if (|eligible) begin
                            state_q <= StLoad;
                        end
                    end
                    StLoad: begin
                        if (found) begin
                            selector_q <= found_idx;
                            credit_q   <= weight[found_idx];
                            serving_q  <= 1'b1;
                            state_q    <= StServe;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StServe: begin
                        if (pop_fire) begin
                            data_q   <= head[selector_q];
                            valid_q  <= 1'b1;
                            credit_q <= credit_q - WEIGHT_BITS'(1);
                            if (credit_q == WEIGHT_BITS'(1)) begin
                                ptr_q     <= next_ptr;
                                serving_q <= 1'b0;
                                state_q   <= StLoad;
                            end
                        end else if (bus.buf_empty[selector_q]) begin
                            // Queue drained early: leftover credit is forfeited.
                            ptr_q     <= next_ptr;
                            serving_q <= 1'b0;
                            state_q   <= StLoad;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef WRR_GRANT_COUNT_EN
    logic [15:0] grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
        end else if (pop_fire && (grant_q != 16'hFFFF)) begin
            grant_q <= grant_q + 16'd1;
        end
    end

    assign grant_total = grant_q;
`endif

    assign bus.pop          = pop_vec;
    assign bus.data_out     = data_q;
    assign bus.valid_out    = valid_q;
    assign bus.selector     = selector_q;
    assign bus.selector_enb = serving_q;

endmodule

// File: tb/tb_wrr_pop_controller.sv
// Directed self-checking bench for wrr_pop_controller (4 queues, 8-bit data).
module tb_wrr_pop_controller;

    localparam int unsigned QQ = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned MW = 64;
    localparam int unsigned WB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic [QQ*WB-1:0] pesos;
`ifdef WRR_GRANT_COUNT_EN
    logic [15:0]   grant_total;
`endif

    int checks   = 0;
    int failures = 0;

    wrr_pop_controller_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus ();

    wrr_pop_controller #(
        .QUEUE_QUANTITY (QQ),
        .DATA_BITS      (DB),
        .MAX_WEIGHT     (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .pesos       (pesos),
`ifdef WRR_GRANT_COUNT_EN
        .grant_total (grant_total),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Head words: q0=A0, q1=B1, q2=C2, q3=D3.
    function automatic logic [7:0] head_of(input int q);
        logic [31:0] words;
        words = 32'hD3C2B1A0;
        return words[q*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [QQ*WB-1:0] w, input logic [3:0] empty);
        rst = 1'b1;
        enb = 1'b1;
        pesos = w;
        bus.buf_empty = empty;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start({6'd1, 6'd1, 6'd1, 6'd1}, 4'b0000);
        rst = 1'b1;
        step();
        checks++;
        if (bus.pop !== 4'b0000) begin
            failures++; $display("FAIL reset_pop got %b expected 0000", bus.pop);
        end
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got valid=%b data=%h expected 0/00", bus.valid_out, bus.data_out);
        end
        checks++;
        if (bus.selector !== 2'd0 || bus.selector_enb !== 1'b0) begin
            failures++;
            $display("FAIL reset_sel got sel=%0d enb=%b expected 0/0", bus.selector, bus.selector_enb);
        end
        rst = 1'b0;
    endtask

    task automatic test_equal_weights();
        logic [3:0] exp_pop [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        logic exp_valid;
        start({6'd1, 6'd1, 6'd1, 6'd1}, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (bus.pop !== exp_pop[k-1]) begin
                failures++; $display("FAIL equal_pop step %0d got %b expected %b", k, bus.pop, exp_pop[k-1]);
            end
            exp_valid = (k >= 3) && (k % 2 == 1);
            checks++;
            if (bus.valid_out !== exp_valid) begin
                failures++; $display("FAIL equal_valid step %0d got %b expected %b", k, bus.valid_out, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (bus.data_out !== head_of((k - 3) / 2)) begin
                    failures++;
                    $display("FAIL equal_data step %0d got %h expected %h", k, bus.data_out, head_of((k - 3) / 2));
                end
            end
        end
    endtask

    task automatic test_weighted();
        logic [3:0] exp_pop [11] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
        start({6'd2, 6'd0, 6'd1, 6'd3}, 4'b0000);
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++;
            if (bus.pop !== exp_pop[k-1]) begin
                failures++; $display("FAIL weighted_pop step %0d got %b expected %b", k, bus.pop, exp_pop[k-1]);
            end
        end
    endtask

    task automatic test_empty_exit();
        logic [3:0] exp_pop [4] = '{4'h0, 4'h2, 4'h2, 4'h2};
        start({6'd1, 6'd1, 6'd5, 6'd1}, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.pop !== exp_pop[k-1]) begin
                failures++; $display("FAIL empty_pop step %0d got %b expected %b", k, bus.pop, exp_pop[k-1]);
            end
        end
        bus.buf_empty = 4'b0011;
        step();
        checks++;
        if (bus.pop !== 4'h0 || bus.selector_enb !== 1'b0 || bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL empty_exit got pop=%b sel_enb=%b valid=%b expected 0000/0/0",
                     bus.pop, bus.selector_enb, bus.valid_out);
        end
        step();
        checks++;
        if (bus.selector !== 2'd2 || bus.pop !== 4'h4) begin
            failures++;
            $display("FAIL empty_next got sel=%0d pop=%b expected 2/0100", bus.selector, bus.pop);
        end
    endtask

    task automatic test_out_ready_stall();
        start({6'd1, 6'd1, 6'd1, 6'd3}, 4'b0000);
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.pop !== 4'h0) begin
            failures++; $display("FAIL stall_pop_now got %b expected 0000", bus.pop);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.pop !== 4'h0 || bus.valid_out !== 1'b0 || bus.selector_enb !== 1'b1
                || bus.selector !== 2'd0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got pop=%b valid=%b sel_enb=%b sel=%0d expected 0000/0/1/0",
                         k, bus.pop, bus.valid_out, bus.selector_enb, bus.selector);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.pop !== 4'h1) begin
            failures++; $display("FAIL stall_resume got %b expected 0001", bus.pop);
        end
        step();
        checks++;
        if (bus.pop !== 4'h1 || bus.valid_out !== 1'b1) begin
            failures++; $display("FAIL stall_credit got pop=%b valid=%b expected 0001/1", bus.pop, bus.valid_out);
        end
        step();
        checks++;
        if (bus.pop !== 4'h0 || bus.selector_enb !== 1'b0 || bus.valid_out !== 1'b1) begin
            failures++;
            $display("FAIL stall_exit got pop=%b sel_enb=%b valid=%b expected 0000/0/1",
                     bus.pop, bus.selector_enb, bus.valid_out);
        end
        step();
        checks++;
        if (bus.selector !== 2'd1 || bus.pop !== 4'h2) begin
            failures++; $display("FAIL stall_next got sel=%0d pop=%b expected 1/0010", bus.selector, bus.pop);
        end
    endtask

    task automatic test_enable_freeze();
        start({6'd1, 6'd1, 6'd1, 6'd2}, 4'b0000);
        step();
        step();
        enb = 1'b0;
        #1;
        checks++;
        if (bus.pop !== 4'h0) begin
            failures++; $display("FAIL freeze_pop_now got %b expected 0000", bus.pop);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.pop !== 4'h0 || bus.valid_out !== 1'b0 || bus.selector_enb !== 1'b1) begin
                failures++;
                $display("FAIL freeze_hold cycle %0d got pop=%b valid=%b sel_enb=%b expected 0000/0/1",
                         k, bus.pop, bus.valid_out, bus.selector_enb);
            end
        end
        enb = 1'b1;
        step();
        checks++;
        if (bus.pop !== 4'h1 || bus.valid_out !== 1'b1 || bus.data_out !== 8'hA0) begin
            failures++;
            $display("FAIL freeze_resume got pop=%b valid=%b data=%h expected 0001/1/a0",
                     bus.pop, bus.valid_out, bus.data_out);
        end
        step();
        checks++;
        if (bus.pop !== 4'h0 || bus.selector_enb !== 1'b0) begin
            failures++; $display("FAIL freeze_exit got pop=%b sel_enb=%b expected 0000/0", bus.pop, bus.selector_enb);
        end
    endtask

    task automatic test_reset_mid_serve();
        start({6'd1, 6'd1, 6'd1, 6'd5}, 4'b0000);
        step();
        step();
        step();
        checks++;
        if (bus.pop !== 4'h1 || bus.valid_out !== 1'b1 || bus.data_out !== 8'hA0) begin
            failures++;
            $display("FAIL midrst_pre got pop=%b valid=%b data=%h expected 0001/1/a0",
                     bus.pop, bus.valid_out, bus.data_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pop !== 4'h0) begin
            failures++; $display("FAIL midrst_pop got %b expected 0000", bus.pop);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || bus.selector !== 2'd0
            || bus.selector_enb !== 1'b0 || bus.pop !== 4'h0) begin
            failures++;
            $display("FAIL midrst_state got valid=%b data=%h sel=%0d sel_enb=%b pop=%b expected 0/00/0/0/0000",
                     bus.valid_out, bus.data_out, bus.selector, bus.selector_enb, bus.pop);
        end
        rst = 1'b0;
    endtask

`ifdef WRR_GRANT_COUNT_EN
    task automatic test_grant_count();
        start({6'd1, 6'd1, 6'd1, 6'd1}, 4'b0000);
        for (int k = 0; k < 21; k++) begin
            step();
        end
        enb = 1'b0;
        step();
        checks++;
        if (grant_total !== 16'd10) begin
            failures++; $display("FAIL grant_total got %0d expected 10", grant_total);
        end
        rst = 1'b1;
        step();
        checks++;
        if (grant_total !== 16'd0) begin
            failures++; $display("FAIL grant_clear got %0d expected 0", grant_total);
        end
        rst = 1'b0;
        enb = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        enb = 1'b1;
        pesos = '0;
        bus.buf_empty = 4'hF;
        bus.out_ready = 1'b1;
        bus.fifo_data = 32'hD3C2B1A0;
        test_reset();
        test_equal_weights();
        test_weighted();
        test_empty_exit();
        test_out_ready_stall();
        test_enable_freeze();
        test_reset_mid_serve();
`ifdef WRR_GRANT_COUNT_EN
        test_grant_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
